// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one shift per clock) for the
// leaderboard display path, with saturation and a leading-zero blanking mask.
module score_bcd_converter #(
    parameter int IN_WIDTH  = 20,
    parameter int MAX_SCORE = 999999
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] score,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [3:0]          display_ones,
    output logic [3:0]          display_tens,
    output logic [3:0]          display_hundreds,
    output logic [3:0]          display_thousands,
    output logic [3:0]          display_tthousands,
    output logic [3:0]          display_hthousands,
    output logic [5:0]          lead_mask
);

    localparam int                CNT_W   = $clog2(IN_WIDTH + 1);
    localparam logic [IN_WIDTH-1:0] MAX_VAL = IN_WIDTH'(MAX_SCORE);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(IN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IN_WIDTH-1:0] r_bin;
    logic [23:0]         r_bcd;
    logic [CNT_W-1:0]    r_count;
    logic                r_sat;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;
    logic [23:0]         r_digits;
    logic [5:0]          r_lead_mask;

    logic [23:0]         w_bcd_adj;
    logic [5:0]          w_nz;
    logic [5:0]          w_mask;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_nibble
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                          r_bcd[gi*4 +: 4] + 4'd3 : r_bcd[gi*4 +: 4];
            assign w_nz[gi] = |r_bcd[gi*4 +: 4];
        end
        // A place is shown if it or any higher place is nonzero.
        assign w_mask[5] = w_nz[5];
        for (gi = 0; gi < 5; gi++) begin : g_mask
            assign w_mask[gi] = w_nz[gi] | w_mask[gi+1];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = SHIFT;
            SHIFT:   if (r_count == LAST_CNT) w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin       <= '0;
            r_bcd       <= '0;
            r_count     <= '0;
            r_sat       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_digits    <= '0;
            r_lead_mask <= 6'b000001;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sat   <= (score > MAX_VAL);
                        r_bin   <= (score > MAX_VAL) ? MAX_VAL : score;
                        r_bcd   <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_bcd   <= {w_bcd_adj[22:0], r_bin[IN_WIDTH-1]};
                    r_bin   <= {r_bin[IN_WIDTH-2:0], 1'b0};
                    r_count <= r_count + CNT_W'(1);
                end
                COMMIT: begin
                    r_digits    <= r_bcd;
                    r_lead_mask <= {w_mask[5:1], 1'b1};
                    r_overflow  <= r_sat;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy               = r_busy;
    assign done               = r_done;
    assign overflow           = r_overflow;
    assign lead_mask          = r_lead_mask;
    assign display_ones       = r_digits[3:0];
    assign display_tens       = r_digits[7:4];
    assign display_hundreds   = r_digits[11:8];
    assign display_thousands  = r_digits[15:12];
    assign display_tthousands = r_digits[19:16];
    assign display_hthousands = r_digits[23:20];

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed self-checking bench for score_bcd_converter: latency, digits, mask,
// saturation, start-while-busy and mid-conversion reset.
module tb_score_bcd_converter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [19:0] score;
    logic        busy, done, overflow;
    logic [3:0]  d0, d1, d2, d3, d4, d5;
    logic [5:0]  lead_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    score_bcd_converter dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .score              (score),
        .busy               (busy),
        .done               (done),
        .overflow           (overflow),
        .display_ones       (d0),
        .display_tens       (d1),
        .display_hundreds   (d2),
        .display_thousands  (d3),
        .display_tthousands (d4),
        .display_hthousands (d5),
        .lead_mask          (lead_mask)
    );

    wire [23:0] digits = {d5, d4, d3, d2, d1, d0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one start, return edges from accepting edge until done is seen.
    task automatic run(input logic [19:0] s, output int lat);
        @(negedge clk);
        start = 1'b1;
        score = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("conversion score=%0d latency=%0d digits=%h mask=%b ovf=%b",
                 s, lat, digits, lead_mask, overflow);
    endtask

    initial begin
        int lat;
        int pulses;
        reset = 1'b1;
        start = 1'b0;
        score = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);
        chk("reset_digits", 32'(digits), 32'h000000);
        chk("reset_mask", 32'(lead_mask), 32'b000001);
        @(negedge clk);
        reset = 1'b0;

        // score 0 with cycle-accurate busy/done tracking
        @(negedge clk);
        start = 1'b1;
        score = 20'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("s0_busy_c0", 32'(busy), 32'd1);
        for (int j = 1; j <= 21; j++) begin
            @(posedge clk);
            #1;
            if (j == 1 || j == 20) begin
                chk("s0_busy_mid", 32'(busy), 32'd1);
                chk("s0_done_early", 32'(done), 32'd0);
            end
        end
        chk("s0_done_c21", 32'(done), 32'd1);
        chk("s0_busy_c21", 32'(busy), 32'd0);
        chk("s0_digits", 32'(digits), 32'h000000);
        chk("s0_mask", 32'(lead_mask), 32'b000001);
        chk("s0_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        chk("s0_done_pulse", 32'(done), 32'd0);
        $display("conversion score=0 digits=%h mask=%b", digits, lead_mask);

        run(20'd123456, lat);
        chk("s123456_lat", 32'(lat), 32'd21);
        chk("s123456_digits", 32'(digits), 32'h123456);
        chk("s123456_mask", 32'(lead_mask), 32'b111111);

        run(20'd907, lat);
        chk("s907_lat", 32'(lat), 32'd21);
        chk("s907_digits", 32'(digits), 32'h000907);
        chk("s907_mask", 32'(lead_mask), 32'b000111);

        run(20'd1048575, lat);
        chk("sat_lat", 32'(lat), 32'd21);
        chk("sat_digits", 32'(digits), 32'h999999);
        chk("sat_ovf", 32'(overflow), 32'd1);
        chk("sat_mask", 32'(lead_mask), 32'b111111);

        run(20'd42, lat);
        chk("s42_digits", 32'(digits), 32'h000042);
        chk("s42_ovf", 32'(overflow), 32'd0);
        chk("s42_mask", 32'(lead_mask), 32'b000011);

        // 500 with an ignored start and score change mid-conversion
        @(negedge clk);
        start = 1'b1;
        score = 20'd500;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        score = 20'd777;
        @(negedge clk);
        start = 1'b0;
        score = 20'd888;
        chk("mid_hold_digits", 32'(digits), 32'h000042);
        chk("mid_hold_mask", 32'(lead_mask), 32'b000011);
        chk("mid_busy", 32'(busy), 32'd1);
        pulses = 0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("mid_pulses", 32'(pulses), 32'd1);
        chk("mid_digits", 32'(digits), 32'h000500);
        chk("mid_mask", 32'(lead_mask), 32'b000111);
        $display("conversion score=500 pulses=%0d digits=%h", pulses, digits);

        // 999999 aborted by reset at cycle 12
        @(negedge clk);
        start = 1'b1;
        score = 20'd999999;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_digits", 32'(digits), 32'h000000);
        chk("abort_mask", 32'(lead_mask), 32'b000001);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int j = 0; j < 25; j++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        $display("abort of score=999999 pulses=%0d", pulses);

        run(20'd31, lat);
        chk("s31_lat", 32'(lat), 32'd21);
        chk("s31_digits", 32'(digits), 32'h000031);
        chk("s31_mask", 32'(lead_mask), 32'b000011);

        // reset and start together: reset wins
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        score = 20'd5;
        @(posedge clk);
        #1;
        chk("rs_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("rs_idle", 32'(busy), 32'd0);
        $display("reset with start busy=%b", busy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_bcd_converter.md
Name: score_bcd_converter

Overview:
- Sequential binary-to-BCD converter for the leaderboard display path.
- Takes a binary score and produces the six 4-bit decimal digits (ones..hundred-thousands) that drive the per-digit glyph ROM stage downstream.
- Uses iterative double-dabble: one shift per clock, with a start/busy/done handshake.
- Also produces a leading-zero mask so the display stage can blank unused high places.

Parameters:
- IN_WIDTH, 20, width of the binary score input; 20 bits covers 999999.
- MAX_SCORE, 999999, largest displayable value; larger inputs saturate to it.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- score  input  IN_WIDTH  binary score; captured on the accepted start edge.
- busy  output  1  high while a conversion is in flight.
- done  output  1  one-cycle pulse when new digits are committed.
- overflow  output  1  registered; set when the last converted score exceeded MAX_SCORE.
- display_ones, display_tens, display_hundreds, display_thousands, display_tthousands, display_hthousands  output  4 each  committed BCD digits.
- lead_mask  output  6  bit i = 1 if digit i or any higher digit is nonzero; bit 0 is always 1.

Behaviour:
- Reset
  - Applies at any rising edge with reset=1, including mid-conversion.
  - State goes to IDLE; busy=0, done=0, overflow=0.
  - All six digits = 0; lead_mask = 6'b000001.
  - The shift counter and working registers are cleared.
  - No commit occurs for an aborted conversion.
- States
  - IDLE, SHIFT, COMMIT.
- IDLE
  - start=1 at edge k: capture min(score, MAX_SCORE) into the binary shift register.
  - Clear the 24-bit BCD accumulator, latch the saturation flag, set counter=0, busy=1, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT
  - Each edge, in this order:
    - Every BCD nibble ≥5 gets +3.
    - Shift {bcd, bin} left by 1.
    - counter++.
  - After IN_WIDTH shifts (edges k+1..k+IN_WIDTH), go to COMMIT.
- COMMIT (edge k+IN_WIDTH+1)
  - Load the accumulator nibbles into the display_* outputs atomically.
  - Update lead_mask and overflow; done=1 for exactly this one cycle; busy=0; go to IDLE.
- Latency and throughput
  - done is high in the cycle following edge k+IN_WIDTH+1, i.e. IN_WIDTH+1 = 21 cycles after the accepting edge (default).
  - Latency is fixed regardless of value or saturation.
  - A new start may be accepted on the edge right after the done cycle; back-to-back throughput is one conversion per 22 cycles.
- Start while busy
  - Ignored; it is not queued.
  - score changes after capture have no effect on the conversion.
- Output stability
  - The display_* outputs, lead_mask and overflow hold their previous committed values during SHIFT.
  - The downstream ROM stage therefore never sees partially converted digits.
- Saturation
  - score > MAX_SCORE converts MAX_SCORE, giving all digits 9, and sets overflow=1.
  - The next non-saturated conversion clears overflow at its COMMIT.
- Arithmetic
  - Nibble adds are 4-bit with no carry into the neighbour; the ≥5 precondition guarantees no wrap.
  - The counter is wide enough for IN_WIDTH and never wraps within a conversion.
- Simultaneous reset and start
  - Reset wins; start is dropped.

Test Plan:
- Reset, then start with score=0 → done pulses exactly 21 cycles after the accepting edge; all digits 0; lead_mask=000001; overflow=0; busy high for cycles 1..20 and low with done.
- score=123456 → ones=6, tens=5, hundreds=4, thousands=3, tthousands=2, hthousands=1; lead_mask=111111.
- score=907 → digits 7,0,9,0,0,0; lead_mask=000111.
- score=1048575 → all digits 9; overflow=1. Then score=42 → digits 2,4,0,0,0,0; overflow=0; lead_mask=000011.
- Convert 500, then mid-conversion (cycle 10) pulse start with score=777 and also change score → outputs still show the prior value until commit; result is 500; only one done pulse.
- Start 999999, assert reset at cycle 12 → next cycle busy=0, digits 0, lead_mask=000001, no done pulse. Then start 31 → digits 1,3,0,0,0,0 after 21 cycles.
